// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the SRAM bus arbiter: FSM states, owner codes, default widths.
package enkel_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_PRG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of CPU port, programmer port and SRAM pin signals around the arbiter.
// MEM_ARB_LOCK_EN adds prg_lock, which lets the programmer keep the bus between its own accesses.
interface mem_bus_arbiter_if
    import enkel_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              prg_req;
    logic              prg_we;
    logic [ADDR_W-1:0] prg_addr;
    logic [DATA_W-1:0] prg_wdata;
    logic [DATA_W-1:0] prg_rdata;
    logic              prg_ack;
`ifdef MEM_ARB_LOCK_EN
    logic              prg_lock;
`endif

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_drive;
    logic [DATA_W-1:0] mem_din;
    logic              CS;
    logic              OE;
    logic              WE;
    logic              owner;
    logic              busy;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  prg_req, prg_we, prg_addr, prg_wdata,
        input  mem_din,
`ifdef MEM_ARB_LOCK_EN
        input  prg_lock,
`endif
        output cpu_rdata, cpu_ack, prg_rdata, prg_ack,
        output mem_addr, mem_dout, mem_drive, CS, OE, WE, owner, busy
    );

    // Requester / pin side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output prg_req, prg_we, prg_addr, prg_wdata,
        output mem_din,
`ifdef MEM_ARB_LOCK_EN
        output prg_lock,
`endif
        input  cpu_rdata, cpu_ack, prg_rdata, prg_ack,
        input  mem_addr, mem_dout, mem_drive, CS, OE, WE, owner, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between CPU and programmer plus the rr_last register.
// With MEM_ARB_LOCK_EN, prg_lock masks the CPU while the programmer holds the last grant.
module mem_arb_pick
    import enkel_mem_pkg::*;
#(
    parameter int PROG_PRIORITY = 1
)(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic prg_req,
`ifdef MEM_ARB_LOCK_EN
    input  logic prg_lock,
`endif
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_owner
);

    logic rr_last;
    logic cpu_eff;

`ifdef MEM_ARB_LOCK_EN
    assign cpu_eff = cpu_req & ~(prg_lock & (rr_last == OWNER_PRG));
`else
    assign cpu_eff = cpu_req;
`endif

    // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        grant_valid = cpu_eff | prg_req;
        grant_owner = OWNER_CPU;
        if (cpu_eff && prg_req) begin
            grant_owner = (PROG_PRIORITY != 0) ? OWNER_PRG : ~rr_last;
        end else if (prg_req) begin
            grant_owner = OWNER_PRG;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= OWNER_PRG;
        end else if (grant_en && grant_valid) begin
            rr_last <= grant_owner;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external SRAM between CPU and programmer: one setup/strobe/hold access per grant.
// Optional MEM_ARB_LOCK_EN adds the programmer burst lock (see mem_arb_pick).
module mem_bus_arbiter
    import enkel_mem_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int STROBE_CYC    = 1,
    parameter int PROG_PRIORITY = 1
)(
    input  logic            clk,
    input  logic            master_reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int               CNT_W      = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STROBE_CYC - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] prg_rdata_q;
    logic              grant_en;
    logic              grant_valid;
    logic              grant_owner;
    logic              strobe_last;

    assign grant_en    = (state_q == IDLE);
    assign strobe_last = (state_q == STROBE) && (cnt_q == '0);

    mem_arb_pick #(
        .PROG_PRIORITY (PROG_PRIORITY)
    ) u_pick (
        .clk         (clk),
        .rst         (master_reset),
        .cpu_req     (bus.cpu_req),
        .prg_req     (bus.prg_req),
`ifdef MEM_ARB_LOCK_EN
        .prg_lock    (bus.prg_lock),
`endif
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_q == '0) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= CNT_RELOAD;
        end else if (state_q == STROBE && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Request fields are captured at grant so requesters may change them during the access.
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            owner_q <= OWNER_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_en && grant_valid) begin
            owner_q <= grant_owner;
            if (grant_owner == OWNER_PRG) begin
                we_q    <= bus.prg_we;
                addr_q  <= bus.prg_addr;
                wdata_q <= bus.prg_wdata;
            end else begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end
        end
    end

    // NOTE: read-data holding registers are reset because they drive outputs that must read 0 after reset.
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            cpu_rdata_q <= '0;
            prg_rdata_q <= '0;
        end else if (strobe_last && !we_q) begin
            if (owner_q == OWNER_PRG) prg_rdata_q <= bus.mem_din;
            else                      cpu_rdata_q <= bus.mem_din;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.CS        = (state_q != IDLE);
    assign bus.OE        = (state_q == STROBE) && !we_q;
    assign bus.WE        = (state_q == STROBE) && we_q;
    assign bus.mem_drive = (state_q != IDLE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_dout  = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.cpu_ack   = (state_q == HOLD) && (owner_q == OWNER_CPU);
    assign bus.prg_ack   = (state_q == HOLD) && (owner_q == OWNER_PRG);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.prg_rdata = prg_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: priority instance (STROBE_CYC=1) and round-robin instance (STROBE_CYC=2).
// Build with MEM_ARB_LOCK_EN defined to also exercise the programmer lock.
module tb_mem_bus_arbiter;
    import enkel_mem_pkg::*;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int S_P  = 1;
    localparam int S_RR = 2;

    logic clk = 1'b0;
    logic master_reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_p ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(S_P), .PROG_PRIORITY(1)) dut_p (
        .clk          (clk),
        .master_reset (master_reset),
        .bus          (bus_p.slave)
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(S_RR), .PROG_PRIORITY(0)) dut_rr (
        .clk          (clk),
        .master_reset (master_reset),
        .bus          (bus_rr.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       owner;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        logic [7:0] exp_rdata;
        int         exp_ack_cyc;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] m_cpu_rdata = 8'h00;
    logic [7:0] m_prg_rdata = 8'h00;

    task automatic idle_inputs();
        bus_p.cpu_req   = 1'b0; bus_p.cpu_we   = 1'b0; bus_p.cpu_addr  = '0; bus_p.cpu_wdata  = '0;
        bus_p.prg_req   = 1'b0; bus_p.prg_we   = 1'b0; bus_p.prg_addr  = '0; bus_p.prg_wdata  = '0;
        bus_p.mem_din   = 8'hEE;
        bus_rr.cpu_req  = 1'b0; bus_rr.cpu_we  = 1'b0; bus_rr.cpu_addr = '0; bus_rr.cpu_wdata = '0;
        bus_rr.prg_req  = 1'b0; bus_rr.prg_we  = 1'b0; bus_rr.prg_addr = '0; bus_rr.prg_wdata = '0;
        bus_rr.mem_din  = 8'hEE;
`ifdef MEM_ARB_LOCK_EN
        bus_p.prg_lock  = 1'b0;
        bus_rr.prg_lock = 1'b0;
`endif
    endtask

    // One single-requester access on the priority instance, checked cycle by cycle.
    task automatic run_txn(input string tag, input vec_t v);
        logic is_strobe, is_hold, is_act;
        @(negedge clk);
        if (v.owner == OWNER_PRG) begin
            bus_p.prg_req = 1'b1; bus_p.prg_we = v.we; bus_p.prg_addr = v.addr; bus_p.prg_wdata = v.wdata;
        end else begin
            bus_p.cpu_req = 1'b1; bus_p.cpu_we = v.we; bus_p.cpu_addr = v.addr; bus_p.cpu_wdata = v.wdata;
        end
        bus_p.mem_din = 8'hEE;
        @(posedge clk); #1;
        bus_p.cpu_req   = 1'b0;     bus_p.prg_req   = 1'b0;
        bus_p.cpu_we    = ~v.we;    bus_p.prg_we    = ~v.we;
        bus_p.cpu_addr  = ~v.addr;  bus_p.prg_addr  = ~v.addr;
        bus_p.cpu_wdata = ~v.wdata; bus_p.prg_wdata = ~v.wdata;
        for (int k = 1; k <= v.exp_ack_cyc + 1; k++) begin
            is_act    = (k <= v.exp_ack_cyc);
            is_strobe = (k >= 2) && (k < v.exp_ack_cyc);
            is_hold   = (k == v.exp_ack_cyc);
            bus_p.mem_din = is_strobe ? v.din : 8'hEE;
            if (is_hold && !v.we) begin
                if (v.owner == OWNER_PRG) m_prg_rdata = v.exp_rdata;
                else                      m_cpu_rdata = v.exp_rdata;
            end
            @(negedge clk);
            check1($sformatf("%s k%0d CS", tag, k), bus_p.CS, is_act);
            check1($sformatf("%s k%0d busy", tag, k), bus_p.busy, is_act);
            check1($sformatf("%s k%0d OE", tag, k), bus_p.OE, is_strobe && !v.we);
            check1($sformatf("%s k%0d WE", tag, k), bus_p.WE, is_strobe && v.we);
            check1($sformatf("%s k%0d mem_drive", tag, k), bus_p.mem_drive, is_act && v.we);
            check1($sformatf("%s k%0d cpu_ack", tag, k), bus_p.cpu_ack, is_hold && (v.owner == OWNER_CPU));
            check1($sformatf("%s k%0d prg_ack", tag, k), bus_p.prg_ack, is_hold && (v.owner == OWNER_PRG));
            if (is_act) begin
                check1($sformatf("%s k%0d owner", tag, k), bus_p.owner, v.owner);
                check8($sformatf("%s k%0d mem_addr", tag, k), bus_p.mem_addr, v.addr);
                if (v.we) check8($sformatf("%s k%0d mem_dout", tag, k), bus_p.mem_dout, v.wdata);
            end
            if (is_hold) begin
                check8($sformatf("%s cpu_rdata", tag), bus_p.cpu_rdata, m_cpu_rdata);
                check8($sformatf("%s prg_rdata", tag), bus_p.prg_rdata, m_prg_rdata);
            end
            if (k <= v.exp_ack_cyc) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, c_at, p_at, n_ack, oe_cnt, n_cpu_ack, n_prg_ack;
        logic [1:0] ack_who[4];
        int ack_at[4];
        logic own1;

        vecs[0] = '{OWNER_CPU, 1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A, 3};
        vecs[1] = '{OWNER_PRG, 1'b1, 8'hFF, 8'hC3, 8'h00, 8'h00, 3};
        vecs[2] = '{OWNER_CPU, 1'b1, 8'h00, 8'h3C, 8'h00, 8'h00, 3};
        vecs[3] = '{OWNER_PRG, 1'b0, 8'h80, 8'h00, 8'hA5, 8'hA5, 3};
        vecs[4] = '{OWNER_CPU, 1'b0, 8'h7F, 8'h00, 8'h96, 8'h96, 3};

        master_reset = 1'b1;
        idle_inputs();
        #12;
        check1("reset CS", bus_p.CS, 1'b0);
        check1("reset OE", bus_p.OE, 1'b0);
        check1("reset WE", bus_p.WE, 1'b0);
        check1("reset busy", bus_p.busy, 1'b0);
        check1("reset mem_drive", bus_p.mem_drive, 1'b0);
        check1("reset cpu_ack", bus_p.cpu_ack, 1'b0);
        check1("reset prg_ack", bus_p.prg_ack, 1'b0);
        check1("reset owner", bus_p.owner, 1'b0);
        check8("reset mem_addr", bus_p.mem_addr, 8'h00);
        check8("reset cpu_rdata", bus_p.cpu_rdata, 8'h00);
        check8("reset prg_rdata", bus_p.prg_rdata, 8'h00);
        check1("reset rr busy", bus_rr.busy, 1'b0);
        @(negedge clk);
        master_reset = 1'b0;

        // Table of single-port accesses
        for (int i = 0; i < 5; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous requests with programmer priority
        @(negedge clk);
        bus_p.mem_din = 8'h11;
        bus_p.cpu_req = 1'b1; bus_p.cpu_we = 1'b0; bus_p.cpu_addr = 8'h20;
        bus_p.prg_req = 1'b1; bus_p.prg_we = 1'b1; bus_p.prg_addr = 8'h21; bus_p.prg_wdata = 8'h44;
        cyc = 0; c_at = -1; p_at = -1; n_cpu_ack = 0; n_prg_ack = 0; own1 = 1'b0;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) own1 = bus_p.owner;
            if (bus_p.prg_ack) begin n_prg_ack++; p_at = cyc; bus_p.prg_req = 1'b0; end
            if (bus_p.cpu_ack) begin n_cpu_ack++; c_at = cyc; bus_p.cpu_req = 1'b0; end
        end
        m_cpu_rdata = 8'h11;
        check1("tie first owner", own1, OWNER_PRG);
        check_int("tie prg ack cycle", p_at, 3);
        check_int("tie cpu ack cycle", c_at, 7);
        check_int("tie prg ack count", n_prg_ack, 1);
        check_int("tie cpu ack count", n_cpu_ack, 1);
        check8("tie cpu_rdata", bus_p.cpu_rdata, 8'h11);

        // Round-robin alternation with both requests held
        @(negedge clk);
        bus_rr.mem_din = 8'h77;
        bus_rr.cpu_req = 1'b1; bus_rr.cpu_we = 1'b0; bus_rr.cpu_addr = 8'h01;
        bus_rr.prg_req = 1'b1; bus_rr.prg_we = 1'b0; bus_rr.prg_addr = 8'h02;
        cyc = 0; n_ack = 0; oe_cnt = 0;
        for (int i = 0; i < 4; i++) begin ack_who[i] = 2'd3; ack_at[i] = -1; end
        while (n_ack < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus_rr.OE) oe_cnt++;
            if (bus_rr.cpu_ack || bus_rr.prg_ack) begin
                ack_who[n_ack] = bus_rr.cpu_ack ? 2'd0 : 2'd1;
                ack_at[n_ack]  = cyc;
                n_ack++;
            end
        end
        bus_rr.cpu_req = 1'b0; bus_rr.prg_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("rr grant %0d owner", i), int'(ack_who[i]), i % 2);
            check_int($sformatf("rr grant %0d ack cycle", i), ack_at[i], 4 + 5 * i);
        end
        check_int("rr OE cycles", oe_cnt, 8);
        check8("rr cpu_rdata", bus_rr.cpu_rdata, 8'h77);
        check8("rr prg_rdata", bus_rr.prg_rdata, 8'h77);

        // Reset in the middle of a write strobe
        @(negedge clk);
        bus_p.prg_req = 1'b1; bus_p.prg_we = 1'b1; bus_p.prg_addr = 8'h33; bus_p.prg_wdata = 8'h99;
        @(posedge clk); #1;
        bus_p.prg_req = 1'b0;
        @(posedge clk); #1;
        check1("abort WE before reset", bus_p.WE, 1'b1);
        #1;
        master_reset = 1'b1;
        #1;
        check1("abort CS", bus_p.CS, 1'b0);
        check1("abort WE", bus_p.WE, 1'b0);
        check1("abort mem_drive", bus_p.mem_drive, 1'b0);
        check1("abort busy", bus_p.busy, 1'b0);
        check1("abort prg_ack", bus_p.prg_ack, 1'b0);
        @(negedge clk);
        master_reset = 1'b0;
        n_prg_ack = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_p.prg_ack) n_prg_ack++;
            if (bus_p.busy) cyc++;
        end
        check_int("abort no ack after release", n_prg_ack, 0);
        check_int("abort idle after release", cyc, 0);
        check8("abort cpu_rdata cleared", bus_p.cpu_rdata, 8'h00);
        m_cpu_rdata = 8'h00;
        m_prg_rdata = 8'h00;
        run_txn("post_reset", vecs[0]);

`ifdef MEM_ARB_LOCK_EN
        // Programmer burst under lock while the CPU keeps requesting
        @(negedge clk);
        bus_p.mem_din  = 8'h6D;
        bus_p.prg_lock = 1'b1;
        bus_p.prg_req  = 1'b1; bus_p.prg_we = 1'b1; bus_p.prg_addr = 8'h40; bus_p.prg_wdata = 8'h01;
        bus_p.cpu_req  = 1'b1; bus_p.cpu_we = 1'b0; bus_p.cpu_addr = 8'h50;
        cyc = 0; n_prg_ack = 0; n_cpu_ack = 0;
        while (n_prg_ack < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_p.cpu_ack) n_cpu_ack++;
            if (bus_p.prg_ack) begin
                n_prg_ack++;
                bus_p.prg_addr = bus_p.prg_addr + 8'h01;
                if (n_prg_ack == 3) bus_p.prg_req = 1'b0;
            end
        end
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_p.busy) cyc++;
            if (bus_p.cpu_ack) n_cpu_ack++;
        end
        check_int("lock prg ack count", n_prg_ack, 3);
        check_int("lock cpu ack while locked", n_cpu_ack, 0);
        check_int("lock bus idle while locked", cyc, 0);
        bus_p.prg_lock = 1'b0;
        cyc = 0; c_at = -1;
        while (c_at < 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus_p.cpu_ack) begin c_at = cyc; bus_p.cpu_req = 1'b0; end
        end
        check_int("lock cpu ack after release", c_at, 3);
        check8("lock cpu_rdata", bus_p.cpu_rdata, 8'h6D);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
